wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Capture stage directly downstream of the processing unit.
- Every cycle the PU asserts its register write-enable, this block pushes the write-back value into a circular FIFO. A host or testbench drains the FIFO over a valid/ready interface.
- Counts write-backs lost to overflow, so the execution trace of a program can be checked value by value without stalling the PU, which has no stall input.

Parameters:
- W, 16, data width in bits; at integration this is bound to `WIDTH+1 so it matches the PU write-back bus.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- CW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  PU register write-enable; push request.
- rwd  in  W  PU write-back data; captured when we=1.
- clr  in  1  synchronous clear of the FIFO contents, drop_cnt and ovf; stored data is discarded.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  W  oldest entry (head of the FIFO).
- level  out  log2(DEPTH)+1  current number of stored entries.
- ovf  out  1  sticky flag: at least one push was dropped since the last rst/clr.
- drop_cnt  out  CW  saturating count of dropped pushes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, level=0, out_valid=0, ovf=0, drop_cnt=0.
  - out_data=0; the head data register is cleared.
  - Storage array contents are don't-care.
- rst has priority over clr, and clr has priority over push and pop.
- clr behaves exactly like rst for all outputs and pointers; it affects no other state.
- pop = out_valid & out_ready.
- push = we.
- Push:
  - accepted when level<DEPTH, or when level==DEPTH and pop is asserted in the same cycle (simultaneous pop frees the slot).
  - Accepted: mem[wr_ptr]<=rwd; wr_ptr advances modulo DEPTH.
  - Rejected (full with no pop): the data is discarded, ovf<=1, drop_cnt increments and saturates at 2^CW-1 (it does not wrap).
- Pop: rd_ptr advances modulo DEPTH.
- level update:
  - level+1 on push only.
  - level-1 on pop only.
  - unchanged on both or neither.
- Read side:
  - out_data is combinational from mem[rd_ptr] (first-word fall-through).
  - out_valid = (level!=0).
  - A push into an empty FIFO makes out_valid=1 and out_data=that value in the cycle after the edge. Push-to-visible latency is 1 cycle.
- Push into an empty FIFO with out_ready=1 in the same cycle: no bypass. The pop does not occur, because out_valid was 0.
- Ordering is strict FIFO. Pointers wrap silently. level never exceeds DEPTH and never underflows.
- out_data holds stable while out_valid=1 and out_ready=0.
- When out_valid=0, out_data is don't-care; verification must not check it.
- Reset or clear mid-drain: entries are lost. out_valid falls in the next cycle, and pops in that cycle have no effect.

Test Plan:
1. rst=1 for 2 cycles, then release -> out_valid=0, level=0, ovf=0, drop_cnt=0. 10 idle cycles -> no change.
2. Push 0x0011, 0x0022, 0x0033 on consecutive cycles with out_ready=0 -> level=3 and out_data=0x0011. Then out_ready=1 -> outputs 0x0011, 0x0022, 0x0033 on consecutive cycles, then out_valid=0 and level=0.
3. Push 10 values (1..10) with out_ready=0 and DEPTH=8 -> level=8, ovf=1, drop_cnt=2. Drained sequence is 1..8.
4. FIFO full (level=8); push 0x00AA with out_ready=1 in the same cycle -> push accepted, level stays 8, drop_cnt unchanged, 0x00AA appears as the last drained entry.
5. Continuous push and pop for 20 cycles (pointer wrap, values 0x100+i) -> output equals input delayed one cycle; level alternates 0/1 or holds steady; no drops.
6. Assert clr while level=5 and drop_cnt=3 -> next cycle level=0, out_valid=0, ovf=0, drop_cnt=0. A push in the clr cycle is ignored. Push 0x0777 afterwards -> read back 0x0777.
   - Also run with CW=2 and 5 overflows -> drop_cnt saturates at 3.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures every PU register write-back into a circular FIFO.
// The consumer drains it over a valid/ready interface with first-word
// fall-through. The PU cannot be stalled. A push that finds the FIFO full,
// with no simultaneous pop, is dropped. Dropped pushes set a sticky flag and
// are counted in a saturating counter.
module wb_trace_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [W-1:0]             rwd,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CW-1:0]            drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage holds data only. It needs no reset because out_valid gates every read.
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;

    logic pop;
    logic full;
    logic accept;
    logic reject;

    // The drop counter sticks at all-ones instead of wrapping, so a long overflow
    // burst still reads as "many" and never as a small count.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign full      = (cnt == LW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign pop       = out_valid & out_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot this push needs.
    assign accept    = we & (~full | pop);
    assign reject    = we & full & ~pop;

    // The head is read straight from storage and forced to zero while empty,
    // so after reset or clear the output reads 0.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign level     = cnt;

    // Write accepted push data into storage; reset and clear suppress the write.
    always_ff @(posedge clk) begin
        if (accept && !rst && !clr) begin
            mem[wr_ptr] <= rwd;
        end
    end

    // Update pointers, occupancy and overflow tracking. rst has priority over clr,
    // and clr has priority over push and pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
            if (reject) begin
                ovf      <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Testbench for wb_trace_fifo. Two instances share all inputs: one uses the
// default 8-bit drop counter and the other a 2-bit counter. A queue-based
// reference model predicts contents, level, the overflow flag and the drop
// count after every clock edge.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [15:0] rwd = '0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;

    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        ovf;
    logic [7:0]  drop_cnt;

    logic        out_valid2;
    logic [15:0] out_data2;
    logic [3:0]  level2;
    logic        ovf2;
    logic [1:0]  drop_cnt2;

    int total = 0;
    int bad   = 0;

    // Reference state: stored values in order, plus the true unsaturated drop count.
    logic [15:0] q[$];
    int          drops = 0;
    logic [15:0] popped;

    wb_trace_fifo #(.W(16), .DEPTH(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .we(we), .rwd(rwd), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    wb_trace_fifo #(.W(16), .DEPTH(8), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .we(we), .rwd(rwd), .clr(clr),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .level(level2), .ovf(ovf2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare both instances against the model.
    task automatic check_all();
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("ovf", 32'(ovf), 32'(drops != 0));
        chk("drop_cnt", 32'(drop_cnt), 32'(sat(drops, 255)));
        chk("level2", 32'(level2), 32'(q.size()));
        if (q.size() != 0) chk("out_data2", 32'(out_data2), 32'(q[0]));
        chk("drop_cnt2", 32'(drop_cnt2), 32'(sat(drops, 3)));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input logic r, input logic w, input logic [15:0] d,
                        input logic rdy, input logic c);
        bit do_pop;
        rst = r; we = w; rwd = d; out_ready = rdy; clr = c;
        @(posedge clk);
        if (r || c) begin
            q.delete();
            drops = 0;
        end else begin
            do_pop = (q.size() != 0) && rdy;
            if (do_pop) popped = q.pop_front();
            if (w) begin
                if (q.size() < 8) q.push_back(d);
                else drops++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        // 1: reset, then idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        chk("idle_valid", 32'(out_valid), 32'h0);

        // 2: three pushes, then drain
        step(0, 1, 16'h0011, 0, 0);
        step(0, 1, 16'h0022, 0, 0);
        step(0, 1, 16'h0033, 0, 0);
        chk("t2_level", 32'(level), 32'd3);
        chk("t2_head", 32'(out_data), 32'h0011);
        out_ready = 1'b1;
        chk("t2_d0", 32'(out_data), 32'h0011);
        step(0, 0, 0, 1, 0);
        chk("t2_d1", 32'(out_data), 32'h0022);
        step(0, 0, 0, 1, 0);
        chk("t2_d2", 32'(out_data), 32'h0033);
        step(0, 0, 0, 1, 0);
        chk("t2_empty", 32'(out_valid), 32'h0);

        // 3: overflow by two, then drain 1..8
        for (int i = 1; i <= 10; i++) step(0, 1, 16'(i), 0, 0);
        chk("t3_level", 32'(level), 32'd8);
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_drops", 32'(drop_cnt), 32'd2);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain", 32'(out_data), 32'(i));
            step(0, 0, 0, 1, 0);
        end

        // 4: a push while full succeeds when a pop happens in the same cycle
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0050 + 16'(i), 0, 0);
        step(0, 1, 16'h00AA, 1, 0);
        chk("t4_level", 32'(level), 32'd8);
        chk("t4_drops", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t4_last", 32'(out_data), 32'h00AA);
            step(0, 0, 0, 1, 0);
        end

        // 5: streaming; the head is always the value pushed on the previous edge
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 16'h0100 + 16'(i), 1, 0);
            chk("t5_head", 32'(out_data), 32'h0100 + 32'(i));
            chk("t5_level", 32'(level), 32'd1);
        end
        step(0, 0, 0, 1, 0);
        chk("t5_drops", 32'(drop_cnt), 32'd2);

        // 6: clear mid-drain, including a push in the clear cycle
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) step(0, 1, 16'h0200 + 16'(i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("t6_level", 32'(level), 32'd5);
        chk("t6_drops", 32'(drop_cnt), 32'd3);
        step(0, 1, 16'h0999, 1, 1);
        chk("t6_clr_level", 32'(level), 32'd0);
        chk("t6_clr_valid", 32'(out_valid), 32'd0);
        chk("t6_clr_ovf", 32'(ovf), 32'd0);
        chk("t6_clr_drops", 32'(drop_cnt), 32'd0);
        step(0, 1, 16'h0777, 0, 0);
        chk("t6_readback", 32'(out_data), 32'h0777);
        step(0, 0, 0, 1, 0);

        // 6b: five overflows saturate the 2-bit counter at 3
        for (int i = 0; i < 13; i++) step(0, 1, 16'h0300 + 16'(i), 0, 0);
        chk("t6_sat2", 32'(drop_cnt2), 32'd3);
        chk("t6_cnt8", 32'(drop_cnt), 32'd5);

        // Random traffic with varying drain pressure and occasional clear/reset
        for (int i = 0; i < 600; i++) begin
            int rp;
            rp = (i < 200) ? 30 : (i < 400) ? 70 : 95;
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 99) < 60),
                 16'($urandom),
                 ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
